lpc_record_filter: RTL
======================

# lpc_record_filter

Parametrised record filter and trigger unit between `bufferdomain` and `ringbuffer` in the sniffer datapath. Compares each decoded LPC record against CHANNELS independent value/mask matchers. Forwards records by mode: all, matching only, or a one-shot window that starts at the first match and passes a programmable number of following records. Replaces the fixed single cycle-type trigger compare with runtime-configurable matching, a trigger pulse, per-record hit vector and drop accounting.

## Interface
- `DW`, 48: record width (addr[47:16], data[15:8], timeout[4], cyctype_dir[3:0]).
- `CHANNELS`, 4: number of match channels, 1..8.
- `CW`, 8: width of post-trigger record counter.
- `clock`  in  1  main clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  DW  record from bufferdomain, valid when `in_enable`=1.
- `in_enable`  in  1  one-cycle record strobe.
- `match_value`  in  CHANNELS*DW  channel i at [i*DW +: DW].
- `match_mask`  in  CHANNELS*DW  1 = bit compared; channel i at [i*DW +: DW].
- `channel_enable`  in  CHANNELS  1 = channel participates.
- `mode`  in  2  0 pass-all, 1 pass-matching, 2 window, 3 = pass-all.
- `arm`  in  1  one-cycle pulse; (re)starts window mode.
- `post_count`  in  CW  records forwarded after the triggering record.
- `out_data`  out  DW  record to ringbuffer.
- `out_enable`  out  1  one-cycle write strobe.
- `out_hits`  out  CHANNELS  hit vector of the record on `out_data`.
- `trigger`  out  1  one-cycle pulse on window trigger.
- `state`  out  2  FSM state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- `dropped`  out  16  saturating count of records not forwarded.

## Operation
- Channel hit: `hit[i] = channel_enable[i] & (((in_data ^ value_i) & mask_i) == 0)`; all-zero mask with enable = match-all. `any_hit = |hit`.
- Config inputs sampled live at each `in_enable`; changes apply to the next record.
- Mode 0/3: every record forwarded; FSM held in IDLE.
- Mode 1: record forwarded iff `any_hit`.
- Mode 2 FSM (only active in mode 2; leaving mode 2 forces IDLE next cycle):
  - IDLE: drop all. `arm` -> ARMED.
  - ARMED: drop non-matching. Matching record: forward, `trigger` pulse, counter <= `post_count`; -> DONE if `post_count`=0 else -> CAPTURE.
  - CAPTURE: forward every record regardless of hits; counter decrements per record; record that takes counter 1->0 forwarded, -> DONE.
  - DONE: drop all until `arm` -> ARMED.
- `arm` in any state -> ARMED, counter cleared. Record in same cycle as `arm` evaluated against the pre-arm state; `arm` wins next state, overriding any transition that record would cause (its forward/trigger still emitted).
- `arm` while not in mode 2 ignored.
- `dropped` increments once per `in_enable` not forwarded; saturates at 16'hFFFF; cleared only by reset.
- `out_hits` carries the hit vector even in mode 0 (may be 0).

## Timing
- Latency 1: `in_enable` at edge N -> `out_enable`, `out_data`, `out_hits`, `trigger` registered, valid for exactly cycle N+1.
- `out_enable` and `trigger` high for one cycle only; back-to-back `in_enable` gives back-to-back outputs, full throughput.
- `out_data`/`out_hits` hold last forwarded value when `out_enable`=0.
- `state` and counter update at the same edge as the output registers.
- Reset (async assert, any time incl. mid-CAPTURE): `out_data`=0, `out_hits`=0, `out_enable`=0, `trigger`=0, `state`=IDLE, counter=0, `dropped`=0. First record accepted on first edge after deassertion.
- No backpressure: ringbuffer overflow handled downstream.

## Test plan
- Mode 0, 5 back-to-back records -> 5 `out_enable` pulses, each one cycle after input, data identical, `dropped`=0.
- Mode 1, ch0 value addr=32'h80 cyctype 4'b0010, mask addr+cyctype; send addr 0x80, 0x81, 0x80 -> 2 forwarded, `out_hits`=4'b0001, `dropped`=1.
- Mode 2, `post_count`=3, ch1 cyctype 4'b0100; arm, 2 non-matching, 1 match, 5 more -> `trigger` once with match, 4 forwarded total, state DONE, `dropped`=4.
- Mode 2, `post_count`=0 -> only triggering record forwarded, state ARMED->DONE directly; re-arm with a matching record in the same cycle -> record dropped (DONE pre-arm), state ARMED.
- Reset asserted mid-CAPTURE with counter=2 -> all outputs 0, state IDLE immediately; no further forwards in mode 2 until `arm`.
- Mode 1, all channels disabled, 70000 records -> no forwards, `dropped` saturates at 16'hFFFF.

Source files
------------

// File: rtl/lpc_record_filter.sv
// LPC record filter/trigger: CHANNELS value/mask matchers gate records by mode (all, matching, one-shot window).
// Latency 1 cycle from in_enable to out_enable/out_data/out_hits/trigger; no backpressure, full throughput.
module lpc_record_filter #(
  parameter int DW       = 48,
  parameter int CHANNELS = 4,
  parameter int CW       = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_enable,
  input  logic [CHANNELS*DW-1:0] match_value,
  input  logic [CHANNELS*DW-1:0] match_mask,
  input  logic [CHANNELS-1:0]    channel_enable,
  input  logic [1:0]             mode,
  input  logic                   arm,
  input  logic [CW-1:0]          post_count,
  output logic [DW-1:0]          out_data,
  output logic                   out_enable,
  output logic [CHANNELS-1:0]    out_hits,
  output logic                   trigger,
  output logic [1:0]             state,
  output logic [15:0]            dropped
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         out_data_q, out_data_d;
  logic [CHANNELS-1:0]   out_hits_q, out_hits_d;
  logic                  out_enable_q, out_enable_d;
  logic                  trigger_q, trigger_d;
  logic [15:0]           dropped_q, dropped_d;

  logic [CHANNELS-1:0]   hit;
  logic                  any_hit;
  logic                  fwd;

  always_comb begin
    hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i] = channel_enable[i] &
               (((in_data ^ match_value[i*DW +: DW]) & match_mask[i*DW +: DW]) == '0);
    end
    any_hit = |hit;
  end

  always_comb begin
    fwd       = 1'b0;
    trigger_d = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;

    if (mode != 2'd2) begin
      // Window FSM only runs in mode 2; other modes park it in IDLE.
      state_d = IDLE;
      cnt_d   = '0;
      fwd     = in_enable & ((mode == 2'd1) ? any_hit : 1'b1);
    end else begin
      unique case (state_q)
        ARMED: begin
          if (in_enable && any_hit) begin
            fwd       = 1'b1;
            trigger_d = 1'b1;
            cnt_d     = post_count;
            state_d   = (post_count == '0) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (in_enable) begin
            fwd   = 1'b1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q <= CW'(1)) begin
              state_d = DONE;
              cnt_d   = '0;
            end
          end
        end
        default: ;
      endcase
      // The record seen with arm was judged on the old state; arm still owns the next state.
      if (arm) begin
        state_d = ARMED;
        cnt_d   = '0;
      end
    end

    out_enable_d = fwd;
    out_data_d   = fwd ? in_data : out_data_q;
    out_hits_d   = fwd ? hit : out_hits_q;

    dropped_d = dropped_q;
    if (in_enable && !fwd && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_hits_q   <= '0;
      out_enable_q <= 1'b0;
      trigger_q    <= 1'b0;
      dropped_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_hits_q   <= out_hits_d;
      out_enable_q <= out_enable_d;
      trigger_q    <= trigger_d;
      dropped_q    <= dropped_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_hits   = out_hits_q;
  assign out_enable = out_enable_q;
  assign trigger    = trigger_q;
  assign state      = state_q;
  assign dropped    = dropped_q;

endmodule
